// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a bouncy switch waveform with LFSR-spaced toggles.
// Latency: 2 clocks from A_clean (sync) to first A_noisy edge; no backpressure, bursts restart on retarget.
module switch_bounce_gen #(
  parameter int          BOUNCES      = 6,
  parameter int          MIN_INTERVAL = 4,
  parameter int          INTERVAL_W   = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       Clock50M,
  input  logic       reset_n,
  input  logic       A_clean,
  output logic       A_noisy,
  output logic       busy,
  output logic [7:0] glitch_count
);

  localparam int TW = $clog2(MIN_INTERVAL + (1 << INTERVAL_W)) + 1;
  localparam int CW = $clog2(2 * BOUNCES + 1) + 1;
  localparam logic [CW-1:0] TOG_INIT = CW'(2 * BOUNCES);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          sync_q, sync_d;
  logic          target_q, target_d;
  logic          noisy_q, noisy_d;
  logic          busy_q, busy_d;
  logic [7:0]    glitch_q, glitch_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] toggles_q, toggles_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] interval;

  assign interval = TW'(MIN_INTERVAL) + TW'(lfsr_q[INTERVAL_W-1:0]);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    noisy_d   = noisy_q;
    glitch_d  = glitch_q;
    timer_d   = timer_q;
    toggles_d = toggles_q;
    s1_d      = A_clean;
    sync_d    = s1_q;

    // x^16+x^14+x^13+x^11+1; the zero guard only matters if the seed is misconfigured
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (lfsr_d == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end

    case (state_q)
      IDLE: begin
        noisy_d = target_q;
        if (sync_q != target_q) begin
          target_d  = sync_q;
          noisy_d   = sync_q;
          glitch_d  = glitch_q + 8'd1;
          toggles_d = TOG_INIT;
          timer_d   = interval;
          if (BOUNCES > 0) begin
            state_d = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        if (sync_q != target_q) begin
          // Retarget restarts the whole burst from the new level
          target_d  = sync_q;
          noisy_d   = sync_q;
          toggles_d = TOG_INIT;
          timer_d   = interval;
          if (noisy_q != sync_q) begin
            glitch_d = glitch_q + 8'd1;
          end
        end else if (timer_q == TW'(1)) begin
          noisy_d   = ~noisy_q;
          glitch_d  = glitch_q + 8'd1;
          toggles_d = toggles_q - CW'(1);
          timer_d   = interval;
          if (toggles_q == CW'(1)) begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BOUNCE);
  end

  always_ff @(posedge Clock50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      sync_q    <= 1'b0;
      target_q  <= 1'b0;
      noisy_q   <= 1'b0;
      busy_q    <= 1'b0;
      glitch_q  <= 8'd0;
      timer_q   <= '0;
      toggles_q <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      sync_q    <= sync_d;
      target_q  <= target_d;
      noisy_q   <= noisy_d;
      busy_q    <= busy_d;
      glitch_q  <= glitch_d;
      timer_q   <= timer_d;
      toggles_q <= toggles_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign A_noisy      = noisy_q;
  assign busy         = busy_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: event recorder plus a cycle-level LFSR reference predicting every bounce spacing.
module tb_switch_bounce_gen;

  localparam int MINI = 4;
  localparam int IW   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a3 = 1'b0;
  logic       a0 = 1'b0;
  logic       n3, b3, n0, b0;
  logic [7:0] gc3, gc0;

  switch_bounce_gen #(.BOUNCES(3), .MIN_INTERVAL(MINI), .INTERVAL_W(IW), .LFSR_SEED(16'hACE1)) dut3 (
    .Clock50M(clk), .reset_n(rst_n), .A_clean(a3), .A_noisy(n3), .busy(b3), .glitch_count(gc3));

  switch_bounce_gen #(.BOUNCES(0), .MIN_INTERVAL(MINI), .INTERVAL_W(IW), .LFSR_SEED(16'hACE1)) dut0 (
    .Clock50M(clk), .reset_n(rst_n), .A_clean(a0), .A_noisy(n0), .busy(b0), .glitch_count(gc0));

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: lf_prev is the value the DUT saw just before the latest edge
  logic [15:0] lf_m, lf_prev;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_m    <= 16'hACE1;
      lf_prev <= 16'hACE1;
    end else begin
      lf_prev <= lf_m;
      lf_m    <= lfsr_step(lf_m);
    end
  end

  // Transition recorder: each edge of A_noisy with the interval the spec predicts from that edge
  int   ev_cyc[$];
  int   ev_int[$];
  bit   ev_val[$];
  bit   ev_busy[$];
  logic prev_n3 = 1'b0;
  int   b3_high = 0;
  int   b0_high = 0;

  always @(posedge clk) begin
    #1;
    if (n3 !== prev_n3) begin
      ev_cyc.push_back(cyc);
      ev_val.push_back(n3);
      ev_busy.push_back(b3);
      ev_int.push_back(MINI + int'(lf_prev[IW-1:0]));
    end
    prev_n3 = n3;
    if (b3 === 1'b1) b3_high++;
    if (b0 === 1'b1) b0_high++;
  end

  // Loopback consumer: a stable-for-24-cycles debouncer clocking a toggle flop
  logic deb = 1'b0, last = 1'b0, ffq = 1'b0;
  int   scnt = 0;
  int   deb_rise = 0;

  always @(posedge clk) begin
    if (n3 !== last) scnt <= 0;
    else if (scnt < 31) scnt <= scnt + 1;
    last <= n3;
    if (scnt == 24) deb <= last;
  end

  always @(posedge deb) begin
    deb_rise++;
    ffq <= ~ffq;
  end

  task automatic clear_ev();
    ev_cyc.delete(); ev_int.delete(); ev_val.delete(); ev_busy.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst_n = 1'b0; a3 = lvl; a0 = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    clear_ev();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; a3 = 1'b1; a0 = 1'b0;
    wait_cyc(3);
    checks++; if (n3 !== 1'b0) begin failures++; $display("FAIL reset_noisy: got %b expected 0", n3); end
    checks++; if (b3 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", b3); end
    checks++; if (gc3 !== 8'd0) begin failures++; $display("FAIL reset_gc: got %0d expected 0", gc3); end
    rst_n = 1'b1;
    clear_ev();
    wait_cyc(2);
    checks++; if (n3 !== 1'b0) begin failures++; $display("FAIL reset_latency_early: got %b expected 0", n3); end
    wait_cyc(1);
    checks++; if (n3 !== 1'b1) begin failures++; $display("FAIL reset_latency_rise: got %b expected 1", n3); end
    wait_cyc(150);
    checks++; if (gc3 !== 8'd7) begin failures++; $display("FAIL reset_burst_gc: got %0d expected 7", gc3); end
  endtask

  task automatic test_single_press();
    int t0, sp;
    do_reset(1'b0);
    wait_cyc(5);
    b3_high = 0;
    a3 = 1'b1; t0 = cyc;
    wait_cyc(150);
    checks++; if (ev_cyc.size() != 7) begin failures++; $display("FAIL press_count: got %0d expected 7", ev_cyc.size()); end
    if (ev_cyc.size() >= 7) begin
      checks++; if (ev_cyc[0] != t0 + 3) begin failures++; $display("FAIL press_latency: got %0d expected %0d", ev_cyc[0] - t0, 3); end
      for (int i = 1; i < 7; i++) begin
        sp = ev_cyc[i] - ev_cyc[i-1];
        checks++; if (sp != ev_int[i-1]) begin failures++; $display("FAIL press_spacing%0d: got %0d expected %0d", i, sp, ev_int[i-1]); end
        checks++; if (sp < 4 || sp > 19) begin failures++; $display("FAIL press_range%0d: got %0d expected 4..19", i, sp); end
      end
      for (int i = 0; i < 7; i++) begin
        checks++; if (ev_val[i] != (i % 2 == 0)) begin failures++; $display("FAIL press_level%0d: got %b expected %b", i, ev_val[i], (i % 2 == 0)); end
        checks++; if (ev_busy[i] != (i < 6)) begin failures++; $display("FAIL press_busy%0d: got %b expected %b", i, ev_busy[i], (i < 6)); end
      end
      checks++; if (b3_high != ev_cyc[6] - ev_cyc[0]) begin failures++; $display("FAIL press_busy_span: got %0d expected %0d", b3_high, ev_cyc[6] - ev_cyc[0]); end
    end
    checks++; if (n3 !== 1'b1) begin failures++; $display("FAIL press_final: got %b expected 1", n3); end
    checks++; if (gc3 !== 8'd7) begin failures++; $display("FAIL press_gc: got %0d expected 7", gc3); end
  endtask

  task automatic test_release_mid();
    int n, t1, sp;
    a3 = 1'b0;
    wait_cyc(150);
    clear_ev();
    b3_high = 0;
    a3 = 1'b1;
    n = 0;
    while (ev_cyc.size() < 3 && n < 200) begin @(negedge clk); n++; end
    checks++; if (ev_cyc.size() < 3) begin failures++; $display("FAIL mid_timeout: got %0d events expected 3", ev_cyc.size()); end
    a3 = 1'b0; t1 = cyc;
    wait_cyc(200);
    checks++; if (ev_cyc.size() != 10) begin failures++; $display("FAIL mid_count: got %0d expected 10", ev_cyc.size()); end
    if (ev_cyc.size() >= 10) begin
      checks++; if (ev_cyc[3] != t1 + 3 || ev_val[3] != 1'b0) begin failures++; $display("FAIL mid_retarget: got cyc+%0d val %b expected cyc+3 val 0", ev_cyc[3] - t1, ev_val[3]); end
      for (int i = 1; i < 10; i++) begin
        if (i != 3) begin
          sp = ev_cyc[i] - ev_cyc[i-1];
          checks++; if (sp != ev_int[i-1]) begin failures++; $display("FAIL mid_spacing%0d: got %0d expected %0d", i, sp, ev_int[i-1]); end
        end
      end
      checks++; if (b3_high != ev_cyc[9] - ev_cyc[0]) begin failures++; $display("FAIL mid_busy_span: got %0d expected %0d", b3_high, ev_cyc[9] - ev_cyc[0]); end
    end
    checks++; if (n3 !== 1'b0) begin failures++; $display("FAIL mid_final: got %b expected 0", n3); end
    checks++; if (gc3 !== 8'd24) begin failures++; $display("FAIL mid_gc: got %0d expected 24", gc3); end
  endtask

  task automatic test_midburst_reset();
    int n;
    clear_ev();
    a3 = 1'b1;
    n = 0;
    while (ev_cyc.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checks++; if (ev_cyc.size() < 2) begin failures++; $display("FAIL rst_mid_timeout: got %0d events expected 2", ev_cyc.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if (n3 !== 1'b0 || b3 !== 1'b0 || gc3 !== 8'd0) begin failures++; $display("FAIL rst_mid_clear: got n=%b b=%b gc=%0d expected 0 0 0", n3, b3, gc3); end
    a3 = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    clear_ev();
    b3_high = 0;
    wait_cyc(200);
    checks++; if (ev_cyc.size() != 0 || b3_high != 0) begin failures++; $display("FAIL rst_mid_residual: got %0d events busy %0d expected 0 0", ev_cyc.size(), b3_high); end
    checks++; if (gc3 !== 8'd0) begin failures++; $display("FAIL rst_mid_gc: got %0d expected 0", gc3); end
  endtask

  task automatic test_bounce0();
    logic lvl;
    b0_high = 0;
    lvl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lvl = ~lvl; a0 = lvl;
      wait_cyc(2);
      checks++; if (n0 !== ~lvl) begin failures++; $display("FAIL b0_early%0d: got %b expected %b", k, n0, ~lvl); end
      wait_cyc(1);
      checks++; if (n0 !== lvl) begin failures++; $display("FAIL b0_follow%0d: got %b expected %b", k, n0, lvl); end
      wait_cyc(6);
    end
    checks++; if (gc0 !== 8'd4) begin failures++; $display("FAIL b0_gc: got %0d expected 4", gc0); end
    checks++; if (b0_high != 0) begin failures++; $display("FAIL b0_busy: got %0d busy cycles expected 0", b0_high); end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset(1'b0);
    wait_cyc(5);
    for (int k = 0; k < 37; k++) begin
      a3 = ~a3;
      wait_cyc(150);
    end
    bad = 0;
    for (int i = 1; i < ev_cyc.size(); i++) begin
      if (i % 7 != 0 && ev_cyc[i] - ev_cyc[i-1] != ev_int[i-1]) bad++;
    end
    checks++; if (ev_cyc.size() != 259) begin failures++; $display("FAIL wrap_events: got %0d expected 259", ev_cyc.size()); end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_spacing: got %0d bad spacings expected 0", bad); end
    checks++; if (gc3 !== 8'd3) begin failures++; $display("FAIL wrap_gc: got %0d expected 3", gc3); end
    checks++; if (n3 !== 1'b1) begin failures++; $display("FAIL wrap_final: got %b expected 1", n3); end
  endtask

  task automatic test_loopback();
    logic ff0;
    do_reset(1'b0);
    wait_cyc(40);
    deb_rise = 0;
    ff0 = ffq;
    for (int k = 0; k < 5; k++) begin
      a3 = 1'b1;
      wait_cyc(200);
      a3 = 1'b0;
      wait_cyc(200);
    end
    checks++; if (deb_rise != 5) begin failures++; $display("FAIL loop_edges: got %0d expected 5", deb_rise); end
    checks++; if (ffq !== ~ff0) begin failures++; $display("FAIL loop_ff: got %b expected %b", ffq, ~ff0); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release_mid();
    test_midburst_reset();
    test_bounce0();
    test_wrap();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
Synthesizable contact-bounce emulator that turns a clean level into a realistic bouncy switch waveform. It is the transmit-side counterpart of the debouncer: its A_noisy output feeds a debouncer's A_noisy input. It supports on-board and in-bench characterization of the debounce → flip-flop clocking path without a mechanical switch. Bounce spacing comes from a free-running 16-bit LFSR.

Parameters:
BOUNCES, 6, extra toggle pairs emitted per level change (0 = clean passthrough with sync latency)
MIN_INTERVAL, 4, minimum clocks between toggles (≥1)
INTERVAL_W, 10, LFSR bits added to MIN_INTERVAL (1..15); spacing range MIN_INTERVAL .. MIN_INTERVAL+2^INTERVAL_W-1
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
Clock50M  input  1  50 MHz system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
A_clean  input  1  clean requested level (asynchronous to Clock50M, e.g. slide switch)
A_noisy  output  1  emulated bouncy switch output, registered
busy  output  1  high while a bounce burst is in progress, registered
glitch_count  output  8  total A_noisy transitions since reset, wraps 255→0

Behaviour:
- Reset (async, reset_n=0): 2-FF synchronizer=0, target=0, A_noisy=0, busy=0, glitch_count=0, state=IDLE, timer=0, toggles_left=0, lfsr=LFSR_SEED. Outputs low while reset is held. Release takes effect on the next rising edge.
- Synchronizer: A_clean → s1 → s_sync. All decisions use s_sync only.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Advances every cycle out of reset, independent of state. Never loads zero.
- Interval I = MIN_INTERVAL + lfsr[INTERVAL_W-1:0], sampled when the timer is loaded.
- States: IDLE, BOUNCE.
- IDLE:
  - A_noisy holds target.
  - If s_sync != target: target<=s_sync, A_noisy<=s_sync, glitch_count+1, toggles_left<=2*BOUNCES, timer<=I.
  - Go to BOUNCE if BOUNCES>0; otherwise stay in IDLE.
- BOUNCE:
  - timer decrements each cycle.
  - On the cycle timer==1: A_noisy<=~A_noisy, glitch_count+1, toggles_left-1, timer<=I. Consecutive toggles are therefore exactly I cycles apart.
  - When the decrement makes toggles_left 0, return to IDLE on that same edge. Because the toggle count is even, the final level equals target.
- Retarget during BOUNCE (s_sync != target, priority over the timer):
  - target<=s_sync, A_noisy<=s_sync, toggles_left<=2*BOUNCES, timer<=I.
  - glitch_count increments only if A_noisy actually changes.
  - Stay in BOUNCE.
- busy = registered (next_state==BOUNCE). Rises on the edge A_noisy first flips and falls on the edge of the final toggle.
- Latency: a change on A_clean (setup-met before edge 0) reaches s_sync at edge 1 and first changes A_noisy at edge 2.
- Burst length: 1 + 2*BOUNCES transitions per accepted change. Duration is the sum of 2*BOUNCES intervals.
- Pulses on A_clean shorter than 2 clocks may be missed. This is required behaviour, not an error.
- glitch_count arithmetic is 8-bit modulo.
- Mid-burst reset: all state returns to reset values immediately. No residual toggles after release.

Test Plan:
- Reset: reset_n=0 with A_clean=1 → A_noisy=0, busy=0, glitch_count=0. After release, A_noisy first rises at the 2nd edge.
- Single press (BOUNCES=3, MIN_INTERVAL=4, INTERVAL_W=4):
  - A_clean 0→1 → exactly 7 A_noisy transitions, each spacing in [4,19].
  - Final A_noisy=1, glitch_count=7.
  - busy high from first to last transition.
  - Spacings match a bit-exact LFSR reference model.
- Release mid-burst: same config, A_clean 1→0 after the 3rd transition → A_noisy goes to 0 on the next edge after sync, then 6 further transitions ending at 0; busy stays high throughout.
- BOUNCES=0: toggle A_clean 4 times, each spaced 10 cycles → A_noisy follows with 2-edge latency, busy never asserts, glitch_count=4.
- Wrap: 37 presses/releases with BOUNCES=3 (259 transitions) → glitch_count=3.
- Loopback: A_noisy drives the debouncer and a d_ff clock; 5 presses → exactly 5 clean rising edges and 5 flip-flop captures.
